serial_subtractor_ctrl: RTL and testbench



---
 rtl/sub_ctrl_pkg.sv | 15 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor_ctrl.sv | 146 ++++++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_ctrl_pkg.sv
// Shared types and helpers for the bit-serial subtractor controller.
package sub_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } sub_state_e;

  // Bit counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - c, bor set when the result goes negative.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic bor
);

  assign diff = a ^ b ^ c;
  assign bor  = (~a & b) | (~(a ^ b) & c);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a - b, LSB first, one full_subtractor cell reused over WIDTH cycles.
// Define SUB_OVERFLOW_EN to add the registered signed-overflow output ovf_out.
module serial_subtractor_ctrl
  import sub_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  sub_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic             bor_q, bor_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             cell_diff, cell_bor;
  logic [WIDTH-1:0] res_next;

  full_subtractor u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .c    (bor_q),
    .diff (cell_diff),
    .bor  (cell_bor)
  );

  assign res_next = {cell_diff, res_sr_q[WIDTH-1:1]};

`ifdef SUB_OVERFLOW_EN
  logic ovf_q, ovf_d;
  // On the last bit the shift registers hold the operand MSBs at bit 0.
  logic ovf_calc;
  assign ovf_calc = (a_sr_q[0] != b_sr_q[0]) && (cell_diff != a_sr_q[0]);
`endif

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    bor_d    = bor_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SUB_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sr_d  = a_in;
          b_sr_d  = b_in;
          bor_d   = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = res_next;
        bor_d    = cell_bor;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          diff_d   = res_next;
          borrow_d = cell_bor;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = StDone;
`ifdef SUB_OVERFLOW_EN
          ovf_d    = ovf_calc;
`endif
        end
      end
      StDone: begin
        done_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      bor_q    <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      bor_q    <= bor_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SUB_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff_out   = diff_q;
  assign borrow_out = borrow_q;
`ifdef SUB_OVERFLOW_EN
  assign ovf_out    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl: WIDTH=8 vectors and corner sequences, WIDTH=3 sweep.
module tb_serial_subtractor_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, busy8, done8, bor8;
  logic [7:0] a8, b8, diff8;
  logic       start3, busy3, done3, bor3;
  logic [2:0] a3, b3, diff3;
`ifdef SUB_OVERFLOW_EN
  logic       ovf8, ovf3;
`endif

  serial_subtractor_ctrl #(.WIDTH(8)) u_dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start8),
    .a_in       (a8),
    .b_in       (b8),
    .busy       (busy8),
    .done       (done8),
    .diff_out   (diff8),
    .borrow_out (bor8)
`ifdef SUB_OVERFLOW_EN
    , .ovf_out  (ovf8)
`endif
  );

  serial_subtractor_ctrl #(.WIDTH(3)) u_dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start3),
    .a_in       (a3),
    .b_in       (b3),
    .busy       (busy3),
    .done       (done3),
    .diff_out   (diff3),
    .borrow_out (bor3)
`ifdef SUB_OVERFLOW_EN
    , .ovf_out  (ovf3)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       bor;
    logic       ovf;
  } vec_t;

  vec_t vecs[7];

  // One WIDTH=8 operation from IDLE; checks latency, busy, output stability and results.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp_d,
                      input logic exp_b, input logic exp_o, input string tag);
    logic [7:0] prev_d;
    logic       prev_b;
    int         lat;
    bit         stable, busy_ok;
    prev_d  = diff8;
    prev_b  = bor8;
    a8      = a;
    b8      = b;
    start8  = 1'b1;
    tick();
    start8  = 1'b0;
    lat     = 0;
    stable  = 1'b1;
    busy_ok = 1'b1;
    while (!done8 && lat < 40) begin
      if (!busy8) busy_ok = 1'b0;
      if (diff8 !== prev_d || bor8 !== prev_b) stable = 1'b0;
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, 8);
    check({tag, " busy during run"}, busy_ok, 1);
    check({tag, " outputs held in run"}, stable, 1);
    check({tag, " busy at done"}, busy8, 0);
    check({tag, " diff"}, diff8, exp_d);
    check({tag, " borrow"}, bor8, exp_b);
`ifdef SUB_OVERFLOW_EN
    check({tag, " ovf"}, ovf8, exp_o);
`else
    if (exp_o === 1'bx) check({tag, " ovf"}, 0, 1);
`endif
    tick();
    check({tag, " done one cycle"}, done8, 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n_done;
    logic [7:0] got_d;
    bit never_busy;
    int sa, sb, sd;

    vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'h01, 8'h02, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};

    rst_n  = 1'b0;
    start8 = 1'b0;
    start3 = 1'b0;
    a8 = '0; b8 = '0; a3 = '0; b3 = '0;
    tick();
    tick();
    check("reset busy", busy8, 0);
    check("reset done", done8, 0);
    check("reset diff", diff8, 0);
    check("reset borrow", bor8, 0);
    check("reset busy w3", busy3, 0);
`ifdef SUB_OVERFLOW_EN
    check("reset ovf", ovf8, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].bor, vecs[i].ovf, $sformatf("vec%0d", i));
    end

    // Start re-asserted mid-run with new operands must be ignored.
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n_done = 0;
    got_d  = 8'h00;
    for (int i = 0; i < 20; i++) begin
      if (done8) begin
        n_done++;
        got_d = diff8;
      end
      tick();
    end
    check("busy-start done count", n_done, 1);
    check("busy-start diff", got_d, 8'h0F);
    check("busy-start borrow", bor8, 0);

    // Start seen only in the DONE cycle must be ignored.
    a8 = 8'h20; b8 = 8'h01; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 40 && !done8; i++) tick();
    check("done-start done seen", done8, 1);
    a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    never_busy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (busy8 || done8) never_busy = 1'b0;
      tick();
    end
    check("done-start ignored", never_busy, 1);
    check("done-start diff kept", diff8, 8'h1F);

    // Asynchronous reset in the middle of RUN.
    a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre-reset busy", busy8, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid-reset busy", busy8, 0);
    check("mid-reset done", done8, 0);
    check("mid-reset diff", diff8, 0);
    check("mid-reset borrow", bor8, 0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run8(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "post-reset");

    // WIDTH=3 sweep at minimum start-to-start spacing (WIDTH+2 cycles).
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        a3 = 3'(a);
        b3 = 3'(b);
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        tick();
        tick();
        tick();
        check($sformatf("w3 %0d-%0d done", a, b), done3, 1);
        check($sformatf("w3 %0d-%0d diff", a, b), diff3, (a - b) & 7);
        check($sformatf("w3 %0d-%0d borrow", a, b), bor3, (a < b) ? 1 : 0);
`ifdef SUB_OVERFLOW_EN
        sa = (a >= 4) ? a - 8 : a;
        sb = (b >= 4) ? b - 8 : b;
        sd = sa - sb;
        check($sformatf("w3 %0d-%0d ovf", a, b), ovf3, (sd < -4 || sd > 3) ? 1 : 0);
`else
        sa = a;
        sb = b;
        sd = sa - sb;
`endif
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
